// File: rtl/hex_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. One hex-to-7-segment decoder is shared by all four digits. The
// anode rotates every REFRESH_DIV cycles. The first DEAD_CYCLES of each slot
// keep every anode off to suppress ghosting. Displayed values are
// double-buffered and only committed at frame boundaries.
//
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   DEAD_CYCLES  blanked cycles at the start of each slot (< REFRESH_DIV)
//
// Ports:
//   clk         sole clock, rising edge
//   reset_n     synchronous active-low reset
//   load        strobe: capture value/dp_in into the pending buffer
//   value       four hex digits, [3:0] is digit 0 (rightmost)
//   dp_in       per-digit decimal point enable, active-high
//   lz_en       leading-zero suppression enable (live, not buffered)
//   an          anode enables, active-low, an[k] drives digit k
//   hex         segments a..g on bits 6..0, active-low
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse on the last cycle of each frame
//   pending     a loaded value is waiting for the next frame boundary
// ---------------------------------------------------------------------------
module hex_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  hex,
    output logic        dp,
    output logic        frame_tick,
    output logic        pending
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] SLOT_DEAD = CW'(DEAD_CYCLES);

    // Standard hex glyphs, active-low, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'b0000001;
            4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;
            4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;
            4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;
            4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0000100;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b1100000;
            4'hC: seg7 = 7'b0110001;
            4'hD: seg7 = 7'b1000010;
            4'hE: seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit;
    logic [15:0]   disp_val;
    logic [3:0]    disp_dp;
    logic [15:0]   pend_val;
    logic [3:0]    pend_dp;

    logic [CW-1:0] slot_nxt;
    logic [1:0]    digit_nxt;
    logic [15:0]   disp_val_nxt;
    logic [3:0]    disp_dp_nxt;
    logic          commit;
    logic          lz_zero;
    logic          off_nxt;
    logic          tick_nxt;

    // The outputs are registered but must describe the slot the counters hold
    // in the same cycle, so they are computed from the next-state values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        slot_nxt     = slot_cnt + CW'(1);
        digit_nxt    = digit;
        commit       = 1'b0;
        disp_val_nxt = disp_val;
        disp_dp_nxt  = disp_dp;
        lz_zero      = 1'b0;

        if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            digit_nxt = digit + 2'd1;
        end

        // The current cycle is the frame boundary when frame_tick is high.
        commit = frame_tick && pending;
        if (commit) begin
            disp_val_nxt = pend_val;
            disp_dp_nxt  = pend_dp;
        end

        // Digit k is a leading zero when digits k..3 are all zero.
        case (digit_nxt)
            2'd1:    lz_zero = (disp_val_nxt[15:4]  == 12'h000);
            2'd2:    lz_zero = (disp_val_nxt[15:8]  == 8'h00);
            2'd3:    lz_zero = (disp_val_nxt[15:12] == 4'h0);
            default: lz_zero = 1'b0;
        endcase

        off_nxt  = (slot_nxt < SLOT_DEAD) || (lz_en && lz_zero);
        tick_nxt = (slot_nxt == SLOT_LAST) && (digit_nxt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            slot_cnt   <= '0;
            digit      <= 2'd0;
            disp_val   <= 16'h0000;
            disp_dp    <= 4'h0;
            pend_val   <= 16'h0000;
            pend_dp    <= 4'h0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 4'hF;
            hex        <= 7'h7F;
            dp         <= 1'b1;
        end else begin
            slot_cnt   <= slot_nxt;
            digit      <= digit_nxt;
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            frame_tick <= tick_nxt;

            // A load in the commit cycle still wins: the commit used the old
            // buffer above, the new value waits for the following frame.
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end else if (commit) begin
                pending  <= 1'b0;
            end

            if (off_nxt) begin
                an  <= 4'hF;
                hex <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << digit_nxt);
                hex <= seg7(disp_val_nxt[{digit_nxt, 2'b00} +: 4]);
                dp  <= ~disp_dp_nxt[digit_nxt];
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_ctrl
//
// Self-checking bench for hex_scan_ctrl with REFRESH_DIV=8, DEAD_CYCLES=2.
// A reference model tracks the cycle number since reset, the shown and
// pending buffers, and derives the expected anode/segment/dp pattern from
// the slot position with plain arithmetic. Directed scenarios are followed
// by a randomized run.
// ---------------------------------------------------------------------------
module tb_hex_scan_ctrl;

    localparam int R     = 8;
    localparam int D     = 2;
    localparam int FRAME = 4 * R;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  hex;
    logic        dp;
    logic        frame_tick;
    logic        pending;

    hex_scan_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .hex        (hex),
        .dp         (dp),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          t;          // cycle number since the last reset edge
    logic [15:0] m_disp;
    logic [3:0]  m_ddp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    bit          m_pending;
    bit          m_lz;       // lz_en as sampled at the edge entering this cycle
    int          phase;

    // Spot values from the load-and-scan walk-through.
    int         spot_t   [5] = '{2, 34, 42, 50, 58};
    logic [3:0] spot_an  [5] = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] spot_hex [5] = '{7'b0000001, 7'b0111000, 7'b0010010,
                                 7'b0001000, 7'b0000000};

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return tbl[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // One clock cycle: check outputs of the current cycle, drive this cycle's
    // inputs, advance the model across the next rising edge.
    task automatic cycle(input bit rst_i, input bit ld, input logic [15:0] v,
                         input logic [3:0] dpi, input bit lz);
        int   slot, d;
        bit   tick, off;
        logic [3:0] e_an;
        logic [6:0] e_hex;
        logic       e_dp;

        @(negedge clk);
        slot = t % R;
        d    = (t / R) % 4;
        tick = ((t % FRAME) == FRAME - 1);
        off  = (slot < D) || (m_lz && d >= 1 && (m_disp >> (4 * d)) == 16'h0);
        e_an  = off ? 4'hF  : ~(4'b0001 << d);
        e_hex = off ? 7'h7F : glyph(4'((m_disp >> (4 * d)) & 16'hF));
        e_dp  = off ? 1'b1  : ~m_ddp[d];

        check("an",         32'(an),         32'(e_an));
        check("hex",        32'(hex),        32'(e_hex));
        check("dp",         32'(dp),         32'(e_dp));
        check("frame_tick", 32'(frame_tick), 32'(tick));
        check("pending",    32'(pending),    32'(m_pending));

        if (phase == 1) begin
            for (int i = 0; i < 5; i++) begin
                if (t == spot_t[i]) begin
                    check("spot_an",  32'(an),  32'(spot_an[i]));
                    check("spot_hex", 32'(hex), 32'(spot_hex[i]));
                end
            end
        end

        reset_n = rst_i;
        load    = ld;
        value   = v;
        dp_in   = dpi;
        lz_en   = lz;

        if (!rst_i) begin
            t = 0;
            m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0;
            m_pending = 1'b0;
        end else begin
            if (tick && m_pending) begin
                m_disp    = m_pend;
                m_ddp     = m_pdp;
                m_pending = 1'b0;
            end
            if (ld) begin
                m_pend    = v;
                m_pdp     = dpi;
                m_pending = 1'b1;
            end
            t++;
        end
        m_lz = lz;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit lz);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, lz);
    endtask

    // Idle until the model says the current cycle is at frame position pos.
    task automatic idle_to(input int pos, input bit lz);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++)
            cycle(1'b1, 1'b0, 16'h0, 4'h0, lz);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
        phase = 0; t = 0; m_lz = 1'b0;
        m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pending = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held, then release; load 8A2F in cycle 5 and scan it out.
        phase = 1;
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(5, 1'b0);
        cycle(1'b1, 1'b1, 16'h8A2F, 4'h0, 1'b0);
        idle(60 - t, 1'b0);
        phase = 0;

        // Leading-zero suppression.
        cycle(1'b1, 1'b1, 16'h0070, 4'h0, 1'b1);
        idle(2 * FRAME, 1'b1);
        cycle(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
        idle(2 * FRAME, 1'b1);

        // Load A mid-frame, load B in the frame_tick cycle.
        idle_to(12, 1'b0);
        cycle(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
        idle_to(FRAME - 1, 1'b0);
        cycle(1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Reset during the digit 2 ON phase.
        idle_to(2 * R + 4, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        idle(FRAME, 1'b0);

        // Decimal points on digits 0 and 2.
        cycle(1'b1, 1'b1, 16'h4321, 4'b0101, 1'b0);
        idle(2 * FRAME, 1'b0);

        // Randomized run.
        begin
            bit lz_r = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit          rst_r, ld_r;
                logic [15:0] v_r;
                rst_r = ($urandom_range(0, 399) != 0);
                if ((t % FRAME) == FRAME - 1) ld_r = ($urandom_range(0, 2) == 0);
                else                          ld_r = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
                v_r = 16'($urandom) >> (4 * $urandom_range(0, 4));
                cycle(rst_r, ld_r, v_r, 4'($urandom), lz_r);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It shares one instance of the team's 4-bit hex-to-7-segment decoder across four digits. It rotates the active anode at a programmable refresh rate and inserts dead time between digits to suppress ghosting. Displayed values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between value-producing logic (counters, ALU results) and the board's anode, segment and dp pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; must be < `REFRESH_DIV`; 0 disables the dead phase.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `load`  in  1  single-cycle strobe that captures `value` and `dp_in` into the pending buffer.
- `value`  in  16  four hex digits; `[3:0]` is digit 0 (rightmost).
- `dp_in`  in  4  decimal point enable per digit, active-high.
- `lz_en`  in  1  leading-zero suppression enable; sampled live, not buffered.
- `an`  out  4  anode enables, active-low; `an[k]` drives digit k.
- `hex`  out  7  segments, active-low; bit 6 = a … bit 0 = g.
- `dp`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each frame.
- `pending`  out  1  high while a loaded value is waiting to be committed.

## Operation
- Registers:
  - `slot_cnt` is `$clog2(REFRESH_DIV)` bits and counts 0..`REFRESH_DIV`-1.
  - `digit` is 2 bits and counts 0→1→2→3→0, advancing when `slot_cnt` wraps.
  - `disp_val[15:0]` and `disp_dp[3:0]` hold what is shown.
  - `pend_val` and `pend_dp` hold the next value to show.
- Per-slot phase:
  - DEAD while `slot_cnt` < `DEAD_CYCLES`.
  - ON otherwise.
- In DEAD: `an`=1111, `hex`=1111111, `dp`=1.
- In ON for digit k:
  - `an` drives only bit k low.
  - `hex` = decoder(`disp_val[4k+3:4k]`), using the standard glyph set. Examples: 0→0000001, 2→0010010, 7→0001111, 8→0000000, A→0001000, F→0111000.
  - `dp` = ~`disp_dp[k]`.
- Leading-zero suppression: when `lz_en`=1 and k ≥ 1 and `disp_val` digits k..3 are all 0, digit k is blanked.
  - A blanked digit holds `an`=1111, `hex`=1111111 and `dp`=1 for the whole slot.
  - Digit 0 is never blanked.
- Frame boundary: the cycle where `digit`=3 and `slot_cnt`=`REFRESH_DIV`-1. `frame_tick`=1 in that cycle only.
- Load buffering:
  - `load`=1 writes `pend_val`←`value` and `pend_dp`←`dp_in`, and sets `pending`=1 from the next cycle.
  - A second `load` before the commit overwrites the buffer; the latest load wins.
- Commit: on the `frame_tick` edge, if `pending` was 1 before that edge:
  - `disp_*` ← `pend_*`.
  - `pending` is cleared, unless a `load` arrives in the same cycle.
- Load in the `frame_tick` cycle:
  - The commit uses the buffer contents from before that edge.
  - The new load is captured and `pending` stays 1.
  - The new value is shown from the frame after next.
- Reset (`reset_n`=0 at an edge), whether idle or mid-frame:
  - `slot_cnt`=0, `digit`=0.
  - `disp_val`, `disp_dp`, `pend_*` all 0; `pending`=0.
  - `frame_tick`=0, `an`=1111, `hex`=1111111, `dp`=1.

## Timing
- `an`, `hex`, `dp`, `frame_tick` and `pending` are registered outputs. In cycle t they reflect the `digit`/phase that `slot_cnt` holds in cycle t, with no extra pipeline offset.
- Cycle 0 is the first cycle after `reset_n` returns high; it is `slot_cnt`=0 of digit 0.
- One frame is 4·`REFRESH_DIV` cycles. `frame_tick` fires at cycles 4·`REFRESH_DIV`·n − 1.
- Load-to-display latency: from the cycle after the load to the first ON cycle after the next `frame_tick`. The maximum is 4·`REFRESH_DIV` + `DEAD_CYCLES` cycles.
- `lz_en` changes take effect in the same cycle for the slot currently active.

## Test plan
Use `REFRESH_DIV`=8 and `DEAD_CYCLES`=2 unless noted.
- Reset:
  - Hold `reset_n` low 3 cycles → `an`=1111, `hex`=1111111, `dp`=1, `pending`=0, `frame_tick`=0.
  - After release: cycles 0–1 are blank; cycle 2 shows `an`=1110, `hex`=0000001.
- Load and scan:
  - Load 16'h8A2F in cycle 5 → `pending`=1 over cycles 6–31 and `frame_tick`=1 at cycle 31; `pending`=0 at cycle 32.
  - Cycle 34: `an`=1110, `hex`=0111000.
  - Cycle 42: `an`=1101, `hex`=0010010.
  - Cycle 50: `an`=1011, `hex`=0001000.
  - Cycle 58: `an`=0111, `hex`=0000000.
- Leading zeros, with `lz_en`=1:
  - Value 16'h0070 → digit 0 shows `hex`=0000001, digit 1 shows `hex`=0001111, and `an`=1111 throughout the digit 2 and digit 3 slots.
  - Value 16'h0000 → only digit 0 lights.
- Simultaneous load and commit:
  - Load A=16'h1111 mid-frame, then load B=16'h2222 in the `frame_tick` cycle.
  - Next frame shows 1111 with `pending` still 1; the frame after shows 2222 and `pending` falls after the second tick.
- Reset mid-frame:
  - Drive `reset_n` low for one cycle during the digit 2 ON phase.
  - Next cycle: all outputs blank and `pending`=0; the scan restarts at digit 0 showing 0.
- Decimal points:
  - Load with `dp_in`=4'b0101 → `dp`=0 only during the ON phases of digits 0 and 2; `dp`=1 during DEAD phases.
